// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command channel to one Wishbone classic
// cycle per command, with bounded ACK timeout and response channel.
module wb_cmd_master #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_sel_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic [7:0]           err_count_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      state          <= IDLE;
      timer          <= '0;
      cmd_ready_o    <= 1'b1;
      rsp_valid_o    <= 1'b0;
      rsp_dat_o      <= '0;
      rsp_err_o      <= 1'b0;
      WBm_ADR_o      <= '0;
      WBm_CYC_o      <= 1'b0;
      WBm_STB_o      <= 1'b0;
      WBm_WE_o       <= 1'b0;
      WBm_BYTE_STB_o <= '0;
      WBm_DAT_o      <= '0;
      err_count_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            WBm_ADR_o      <= cmd_adr_i;
            WBm_WE_o       <= cmd_we_i;
            WBm_BYTE_STB_o <= cmd_sel_i;
            WBm_DAT_o      <= cmd_dat_i;
            WBm_CYC_o      <= 1'b1;
            WBm_STB_o      <= 1'b1;
            timer          <= '0;
            cmd_ready_o    <= 1'b0;
            state          <= BUS;
          end
        end
        BUS: begin
          // ACK takes priority over an expiring timer
          if (WBm_ACK_i) begin
            rsp_dat_o   <= WBm_WE_o ? '0 : WBm_DAT_i;
            rsp_err_o   <= 1'b0;
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (timer == TLAST) begin
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            WBm_CYC_o   <= 1'b0;
            WBm_STB_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            if (err_count_o != 8'hFF)
              err_count_o <= err_count_o + 8'd1;
            state       <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
